// File: rtl/serial_pkg.sv
// Shared 8N1 framing definitions for the serial receiver and transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

    localparam int STATE_SIZE = 3;
    localparam int DATA_BITS  = 8;

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset value set by RESET_VAL.
// Latency: two clk cycles from d to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronised output).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_sampler.sv
// UART 8N1 receiver: synchronises rx, validates the start bit mid-bit, samples data/stop at bit centres.
// Latency: strobe high the cycle after edge CLK_PER_BIT/2 + 2 + 9*CLK_PER_BIT from start-bit capture.
// Backpressure: none; data is overwritten by the next good byte.
// Ports: clk, rst (sync, active-high), rx (async serial in, idles high),
//        data (last good byte), new_data / frame_err (one-cycle strobes), busy (frame in progress).
module serial_rx_sampler
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int CTR_SIZE    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 new_data,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [CTR_SIZE-1:0] HALF_M1 = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0] FULL_M1 = CTR_SIZE'(CLK_PER_BIT - 1);
    // The synchroniser holds its reset value (line idle) for two clocks after
    // reset, so WAIT_IDLE ignores rx_s until the real pin has reached it.
    // Otherwise a reset in the middle of a low data bit would look like an
    // idle line followed by a fresh start edge.
    localparam logic [CTR_SIZE-1:0] SETTLE  = CTR_SIZE'(2);

    logic rx_s;

    state_t                 state_q, state_d;
    logic [CTR_SIZE-1:0]    ctr_q, ctr_d;
    logic [2:0]             bit_ctr_q, bit_ctr_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_d;
    logic                   new_data_d, frame_err_d, busy_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        bit_ctr_d   = bit_ctr_q;
        shreg_d     = shreg_q;
        data_d      = data;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
                if (!rx_s) begin
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == HALF_M1) begin
                    ctr_d   = '0;
                    // Line back high at mid-bit: a glitch, not a start bit.
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == FULL_M1) begin
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    ctr_d     = '0;
                    bit_ctr_d = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end
                end
            end
            STOP_BIT: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == FULL_M1) begin
                    ctr_d = '0;
                    if (rx_s) begin
                        data_d     = shreg_q;
                        new_data_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (ctr_q != SETTLE) begin
                    ctr_d = ctr_q + 1'b1;
                end else if (rx_s) begin
                    ctr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
                state_d   = WAIT_IDLE;
            end
        endcase

        busy_d = (state_d == START_BIT) || (state_d == DATA) || (state_d == STOP_BIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_IDLE;
            ctr_q     <= '0;
            bit_ctr_q <= '0;
            shreg_q   <= '0;
            data      <= '0;
            new_data  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            bit_ctr_q <= bit_ctr_d;
            shreg_q   <= shreg_d;
            data      <= data_d;
            new_data  <= new_data_d;
            frame_err <= frame_err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_rx_sampler.sv
// Self-checking bench for serial_rx_sampler: table of framed bytes, glitch and mid-frame reset sequences, random frames.
// Expected strobe timing and data come from the framing/latency rules applied to the bench's own line stimulus.
// Line driven one sample per clock from a queue on the falling edge; outputs sampled on the falling edge.
module tb_serial_rx_sampler;

    localparam int CPB = 50;
    localparam int LAT = CPB / 2 + 2 + 9 * CPB;   // 477 clocks from start-bit capture

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    serial_rx_sampler #(.CLK_PER_BIT(CPB), .CTR_SIZE(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .new_data  (new_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         b;
        bit         is_start;
        bit         mark;
        bit         kind;       // 1 = expect frame_err, 0 = expect new_data
        logic [7:0] val;
    } item_t;

    typedef struct {
        int         cyc;
        bit         kind;
        logic [7:0] val;
    } ev_t;

    typedef struct {
        logic [7:0] val;
        bit         stop_ok;
        int         cpb;
        int         gap;
        int         hold;
        bit         chain;
        int         exp_new;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    item_t      lineq[$];
    ev_t        expq[$];
    int         checks = 0;
    int         errors = 0;
    int         n_new = 0;
    int         n_err = 0;
    int         busy_cnt = 0;
    int         start_cyc = 0;
    logic [7:0] model_data = 8'h00;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%02h required=0x%02h", name, cyc, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Queue one 8N1 frame: gap idle clocks, start, 8 data bits LSB first, stop, then hold low clocks.
    task automatic push_frame(input logic [7:0] val, input bit stop_ok, input int cpb,
                              input int gap, input int hold, input bit mark);
        item_t    it;
        bit [9:0] bits;
        bits = {stop_ok, val, 1'b0};
        for (int i = 0; i < gap; i++) begin
            it.b = 1'b1; it.is_start = 1'b0; it.mark = 1'b0; it.kind = 1'b0; it.val = 8'h00;
            lineq.push_back(it);
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < cpb; j++) begin
                it.b        = bits[k];
                it.is_start = (k == 0) && (j == 0);
                it.mark     = mark && (k == 0) && (j == 0);
                it.kind     = !stop_ok;
                it.val      = val;
                lineq.push_back(it);
            end
        end
        for (int i = 0; i < hold; i++) begin
            it.b = 1'b0; it.is_start = 1'b0; it.mark = 1'b0; it.kind = 1'b0; it.val = 8'h00;
            lineq.push_back(it);
        end
    endtask

    task automatic push_low(input int n);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.b = 1'b0; it.is_start = 1'b0; it.mark = 1'b0; it.kind = 1'b0; it.val = 8'h00;
            lineq.push_back(it);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((lineq.size() != 0 || expq.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s_timeout cyc=%0d pending_line=%0d pending_strobes=%0d required=0", name, cyc,
                     lineq.size(), expq.size());
            lineq.delete();
            expq.delete();
        end
        repeat (30) @(negedge clk);
    endtask

    // Line driver and strobe scoreboard.
    initial begin : driver
        item_t it;
        ev_t   e;
        forever begin
            @(negedge clk);
            if (new_data)  n_new++;
            if (frame_err) n_err++;
            if (busy)      busy_cnt++;
            if (new_data || frame_err) begin
                check_bit("strobe_exclusive", new_data && frame_err, 1'b0);
            end
            if (expq.size() != 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                if (e.kind) begin
                    check_bit("frame_err_at_latency", frame_err, 1'b1);
                    check8("data_held_on_frame_err", data, model_data);
                end else begin
                    check_bit("new_data_at_latency", new_data, 1'b1);
                    check8("data_on_new_data", data, e.val);
                    model_data = e.val;
                end
            end else if (new_data || frame_err) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d new_data=%b frame_err=%b required=no strobe",
                         cyc, new_data, frame_err);
            end
            if (lineq.size() != 0) begin
                it = lineq.pop_front();
                rx = it.b;
                if (it.is_start) start_cyc = cyc + 1;
                if (it.mark) begin
                    e.cyc  = cyc + 1 + LAT;
                    e.kind = it.kind;
                    e.val  = it.val;
                    expq.push_back(e);
                end
            end else begin
                rx = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t       tbl[8];
        int         acc_new;
        int         acc_err;
        int         prev_start;
        int         n;
        int         exp_n;
        int         exp_e;
        int         gap;
        bit         bad;
        bit         prev_bad;
        logic [7:0] v;

        tbl[0] = '{8'hA5, 1'b1, 50, 20, 0,   1'b0, 1, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 50, 20, 200, 1'b0, 0, 1, 8'hA5};
        tbl[2] = '{8'h00, 1'b1, 50, 20, 0,   1'b1, 1, 0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 50, 0,  0,   1'b1, 1, 0, 8'hFF};
        tbl[4] = '{8'h55, 1'b1, 50, 0,  0,   1'b0, 1, 0, 8'h55};
        tbl[5] = '{8'hC3, 1'b1, 48, 20, 0,   1'b0, 1, 0, 8'hC3};
        tbl[6] = '{8'h5A, 1'b1, 50, 20, 0,   1'b0, 1, 0, 8'h5A};
        tbl[7] = '{8'hC3, 1'b1, 52, 20, 0,   1'b0, 1, 0, 8'hC3};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check8("reset_data", data, 8'h00);
        check_bit("reset_new_data", new_data, 1'b0);
        check_bit("reset_frame_err", frame_err, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_bit("idle_busy", busy, 1'b0);

        // Table of framed bytes; chained rows go out back-to-back before checking.
        n_new = 0; n_err = 0; acc_new = 0; acc_err = 0;
        for (int i = 0; i < 8; i++) begin
            push_frame(tbl[i].val, tbl[i].stop_ok, tbl[i].cpb, tbl[i].gap, tbl[i].hold, 1'b1);
            acc_new += tbl[i].exp_new;
            acc_err += tbl[i].exp_err;
            if (!tbl[i].chain) begin
                wait_drain($sformatf("vec%0d", i), 4000);
                check_int($sformatf("vec%0d_new_data_count", i), n_new, acc_new);
                check_int($sformatf("vec%0d_frame_err_count", i), n_err, acc_err);
                check8($sformatf("vec%0d_data", i), data, tbl[i].exp_data);
                n_new = 0; n_err = 0; acc_new = 0; acc_err = 0;
            end
        end

        // Glitch: 10-clock low pulse on an idle line.
        n_new = 0; n_err = 0; busy_cnt = 0;
        push_low(10);
        wait_drain("glitch", 200);
        check_int("glitch_new_data_count", n_new, 0);
        check_int("glitch_frame_err_count", n_err, 0);
        check_bit("glitch_busy_within_26", (busy_cnt > 0) && (busy_cnt <= 26), 1'b1);
        check_bit("glitch_busy_low_after", busy, 1'b0);
        check8("glitch_data_unchanged", data, 8'hC3);

        // Reset for one cycle during data bit 4 of 0x81; the frame keeps going on the line.
        n_new = 0; n_err = 0;
        prev_start = start_cyc;
        push_frame(8'h81, 1'b1, CPB, 20, 0, 1'b0);
        n = 0;
        while (start_cyc == prev_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit("midreset_frame_started", start_cyc != prev_start, 1'b1);
        while (cyc < start_cyc + 5 * CPB + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 8'h00;
        check8("midreset_data", data, 8'h00);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_new_data", new_data, 1'b0);
        wait_drain("midreset_tail", 1000);
        repeat (100) @(negedge clk);
        check_int("midreset_new_data_count", n_new, 0);
        check_int("midreset_frame_err_count", n_err, 0);
        check8("midreset_data_after_tail", data, 8'h00);
        push_frame(8'h81, 1'b1, CPB, 20, 0, 1'b1);
        wait_drain("after_reset_frame", 1000);
        check_int("after_reset_new_data_count", n_new, 1);
        check8("after_reset_data", data, 8'h81);

        // Random frames, occasionally with a bad stop bit followed by a low hold.
        n_new = 0; n_err = 0; exp_n = 0; exp_e = 0; prev_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 40) + (prev_bad ? 10 : 0);
            push_frame(v, !bad, CPB, gap, bad ? 120 : 0, 1'b1);
            if (bad) exp_e++;
            else     exp_n++;
            prev_bad = bad;
        end
        wait_drain("random", 8 * 800);
        check_int("random_new_data_count", n_new, exp_n);
        check_int("random_frame_err_count", n_err, exp_e);
        check8("random_final_data", data, model_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
